// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler for the four-FIFO output stage: one pop per cycle
// to the granted FIFO, bounded by a BURST quantum, with mux select/valid aligned to FIFO data.
module fifo_rr_sched #(
  parameter int BURST = 4,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fifo_empty,
  input  logic       dest_pause,
  output logic [3:0] pop,
  output logic [1:0] demux0,
  output logic       valid_out,
  output logic       busy
);
  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

  state_t           state_q;
  logic [1:0]       ptr_q, gnt_q, demux_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic [1:0]       sel_d, cand;
  logic             popping;

  // Scan from the farthest offset down so the nearest non-empty index wins.
  always_comb begin
    sel_d = ptr_q;
    cand  = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (!fifo_empty[cand]) sel_d = cand;
    end
  end

  assign popping = (state_q == SERVE) && !fifo_empty[gnt_q] && !dest_pause && !reset;

  always_comb begin
    pop        = '0;
    pop[gnt_q] = popping;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      demux_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= popping;
      if (popping) demux_q <= gnt_q;
      case (state_q)
        IDLE: begin
          if (!dest_pause && (fifo_empty != 4'hF)) begin
            gnt_q   <= sel_d;
            cnt_q   <= '0;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          // A drained source ends the grant even while paused.
          if (fifo_empty[gnt_q]) begin
            state_q <= IDLE;
            ptr_q   <= gnt_q + 2'd1;
          end else if (popping) begin
            if (cnt_q == LAST) begin
              state_q <= IDLE;
              ptr_q   <= gnt_q + 2'd1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign demux0    = demux_q;
  assign valid_out = valid_q;
  assign busy      = (state_q == SERVE);
endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: BURST=4 and BURST=1 instances fed by word-count FIFO models,
// scored every cycle against a grant-owner reference model plus scenario tables.
module tb_fifo_rr_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       dest_pause;
  logic [3:0] emp     [2];
  logic [3:0] pop_w   [2];
  logic [1:0] demux_w [2];
  logic       valid_w [2];
  logic       busy_w  [2];

  int fcnt [2][4];
  int bur  [2] = '{4, 1};

  // Reference: which FIFO owns the output (-1 = nobody), words served, next search start.
  int         gown   [2] = '{-1, -1};
  int         served [2] = '{0, 0};
  int         start  [2] = '{0, 0};
  int         mdemux [2] = '{0, 0};
  bit         mvalid [2] = '{0, 0};
  logic [3:0] epop   [2];
  logic [3:0] pop_s  [2];
  logic       valid_s[2];
  logic       busy_s [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        emp[d][k] = (fcnt[d][k] == 0);

  fifo_rr_sched #(.BURST(4), .CNT_W(2)) dut4 (
    .clk(clk), .reset(reset), .fifo_empty(emp[0]), .dest_pause(dest_pause),
    .pop(pop_w[0]), .demux0(demux_w[0]), .valid_out(valid_w[0]), .busy(busy_w[0]));

  fifo_rr_sched #(.BURST(1), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(emp[1]), .dest_pause(dest_pause),
    .pop(pop_w[1]), .demux0(demux_w[1]), .valid_out(valid_w[1]), .busy(busy_w[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance model and FIFO contents after the rising edge.
  task automatic cycle();
    int g;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      epop[d] = '0;
      if (!reset && gown[d] >= 0 && fcnt[d][gown[d]] > 0 && !dest_pause)
        epop[d][gown[d]] = 1'b1;
      pop_s[d]   = pop_w[d];
      valid_s[d] = valid_w[d];
      busy_s[d]  = busy_w[d];
      chk($sformatf("pop[b%0d]", bur[d]), int'(pop_w[d]), int'(epop[d]));
      chk($sformatf("valid_out[b%0d]", bur[d]), int'(valid_w[d]), int'(mvalid[d]));
      chk($sformatf("demux0[b%0d]", bur[d]), int'(demux_w[d]), mdemux[d]);
      chk($sformatf("busy[b%0d]", bur[d]), int'(busy_w[d]), (gown[d] >= 0) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      g = gown[d];
      if (reset) begin
        gown[d] = -1; start[d] = 0; served[d] = 0; mdemux[d] = 0; mvalid[d] = 0;
      end else begin
        mvalid[d] = (epop[d] != 0);
        if (epop[d] != 0) mdemux[d] = g;
        if (g < 0) begin
          if (!dest_pause)
            for (int i = 3; i >= 0; i--)
              if (fcnt[d][(start[d] + i) % 4] > 0) begin
                gown[d]   = (start[d] + i) % 4;
                served[d] = 0;
              end
        end else if (fcnt[d][g] == 0) begin
          start[d] = (g + 1) % 4;
          gown[d]  = -1;
        end else if (epop[d] != 0) begin
          served[d]++;
          if (served[d] == bur[d]) begin
            start[d] = (g + 1) % 4;
            gown[d]  = -1;
          end
        end
      end
      if (epop[d] != 0) fcnt[d][g]--;
    end
  endtask

  task automatic do_reset(input int n);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) fcnt[d][k] = 0;
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    int    d;
    bit    rst;
    int    load[4];
    string pops;   // expected pop index per cycle, '-' = no pop
    int    nvalid;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int nv, e;
    byte ch;
    tbl[0] = '{0, 1'b1, '{6, 6, 6, 6}, "-0000-1111-2222-3333-00--11--22--33--", 24};
    tbl[1] = '{0, 1'b1, '{0, 0, 3, 0}, "-222--", 3};
    tbl[2] = '{0, 1'b0, '{1, 0, 0, 1}, "-3--0-", 2};  // start pointer left at 3 by the drain
    tbl[3] = '{1, 1'b1, '{2, 2, 2, 2}, "-0-1-2-3-0-1-2-3-", 8};

    reset = 1'b1;
    dest_pause = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) fcnt[d][k] = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset and idle
    do_reset(2);
    repeat (10) cycle();

    // Scenario table
    for (int s = 0; s < 4; s++) begin
      if (tbl[s].rst) do_reset(2);
      for (int k = 0; k < 4; k++) fcnt[tbl[s].d][k] = tbl[s].load[k];
      nv = 0;
      for (int c = 0; c < tbl[s].pops.len(); c++) begin
        cycle();
        ch = tbl[s].pops[c];
        e  = (ch == 8'h2d) ? 0 : (1 << (int'(ch) - 48));
        chk($sformatf("seq%0d_c%0d_pop", s, c), int'(pop_s[tbl[s].d]), e);
        if (valid_s[tbl[s].d]) nv++;
      end
      chk($sformatf("seq%0d_valid_count", s), nv, tbl[s].nvalid);
    end

    // Backpressure: pause after the 2nd pop of a 4-word FIFO1 burst
    do_reset(2);
    fcnt[0][1] = 4;
    cycle();
    cycle(); chk("bp_pop1", int'(pop_s[0]), 4'b0010);
    cycle(); chk("bp_pop2", int'(pop_s[0]), 4'b0010);
    dest_pause = 1'b1;
    cycle(); chk("bp_word_emerges", int'(valid_s[0]), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle();
      chk("bp_no_pop", int'(pop_s[0]), 0);
      chk("bp_busy", int'(busy_s[0]), 1);
    end
    dest_pause = 1'b0;
    cycle(); chk("bp_pop3", int'(pop_s[0]), 4'b0010);
    cycle(); chk("bp_pop4", int'(pop_s[0]), 4'b0010);
    cycle(); chk("bp_idle_after", int'(busy_s[0]), 0);

    // Reset in the 3rd pop cycle of a FIFO3 burst; start pointer is 2 beforehand
    fcnt[0][3] = 6;
    cycle();
    cycle(); chk("mid_pop1", int'(pop_s[0]), 4'b1000);
    cycle(); chk("mid_pop2", int'(pop_s[0]), 4'b1000);
    reset = 1'b1;
    fcnt[0][1] = 2;
    cycle(); chk("mid_reset_no_pop", int'(pop_s[0]), 0);
    reset = 1'b0;
    cycle();
    cycle(); chk("mid_regrant_fifo1", int'(pop_s[0]), 4'b0010);
    repeat (20) cycle();

    // Randomized traffic, pause and occasional reset on both instances
    do_reset(2);
    for (int n = 0; n < 600; n++) begin
      dest_pause = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 11) == 0) fcnt[d][k] += $urandom_range(1, 4);
      cycle();
    end
    reset = 1'b0;
    dest_pause = 1'b0;
    repeat (60) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
